// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core data-memory port (req/gnt/rvalid) between the
// exu load/store unit (M0) and the debug/system bus master (M1). Round-robin choice,
// the chosen request is held until the memory grants it, and responses are routed back
// in issue order through a small FIFO of master IDs.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,

  output logic        busy_o,
  output logic        spurious_rsp_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q;
  logic             sel_q;         // master frozen while the memory stalls
  logic             last_grant_q;  // master that won the previous handshake

  logic             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             spurious_q;

  logic sel;
  logic sel_req;
  logic can_issue;
  logic handshake;
  logic fifo_empty;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  // A response arriving this cycle frees its slot in time for a new issue.
  assign can_issue  = (count_q < MAX_CNT) | s_rvalid_i;

  // Pick the master driving the port: frozen in HOLD, round-robin on a tie in ARB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = 1'b0;
    if (state_q == HOLD) begin
      sel = sel_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = ~last_grant_q;
    end else begin
      sel = m1_req_i;
    end
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign s_req_o   = sel_req & can_issue;
  assign handshake = s_req_o & s_gnt_i;

  // Payload follows the selected master and stays quiet when it is not requesting.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (sel_req) begin
      s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      s_we_o    = sel ? m1_we_i    : m0_we_i;
      s_be_o    = sel ? m1_be_i    : m0_be_i;
      s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign m0_gnt_o = handshake & ~sel;
  assign m1_gnt_o = handshake &  sel;

  // Response routing: the FIFO head names the master that issued the oldest request.
  assign pop         = s_rvalid_i & ~fifo_empty;
  assign head_id     = fifo_q[rd_ptr_q];
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop &  head_id;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  assign busy_o         = ~fifo_empty | s_req_o;
  assign spurious_rsp_o = spurious_q;

  // Arbitration FSM: enter HOLD on a stalled request, leave on handshake or abort.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= ARB;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        ARB: begin
          if (s_req_o && !s_gnt_i) begin
            state_q <= HOLD;
            sel_q   <= sel;
          end
        end
        HOLD: begin
          if (handshake || !sel_req) begin
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
      if (handshake) begin
        last_grant_q <= sel;
      end
    end
  end

  // ID storage: written on every handshake with the granted master.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; pointers and count define which entries are live.
    if (handshake) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

  // FIFO bookkeeping: pointers wrap at MAX_OUTSTANDING, count tracks live entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (handshake) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for a memory response that no outstanding request can own.
  always_ff @(posedge clk) begin
    if (rst) begin
      spurious_q <= 1'b0;
    end else if (s_rvalid_i && fifo_empty) begin
      spurious_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (ID queue, pending-request slot, round-robin pointer).
module tb_mem_port_arbiter;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        busy_o, spurious_rsp_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0; m0_be_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0;
  endtask

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, spurious_rsp_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, spurious_rsp_o});
    end
    checks++;
    if (s_addr_o !== 32'h0 || s_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload got addr=%h wdata=%h want 0", s_addr_o, s_wdata_o);
    end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h100; s_gnt_i = 1;
    @(negedge clk);
    checks++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b110 || s_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL single_grant got req/g0/g1=%b addr=%h want 110 addr=00000100",
               {s_req_o, m0_gnt_o, m1_gnt_o}, s_addr_o);
    end
    next_cycle();
    m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10 || m0_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rsp got rv0/rv1=%b rdata=%h want 10 deadbeef",
               {m0_rvalid_o, m1_rvalid_o}, m0_rdata_o);
    end
    next_cycle();
    s_rvalid_i = 0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || spurious_rsp_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b spur=%b want 0 0", busy_o, spurious_rsp_o);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'hA0;
    m1_req_i = 1; m1_addr_i = 32'hB0;
    s_gnt_i = 1;
    for (int i = 0; i < 7; i++) begin
      s_rvalid_i = (i > 0);
      if (i == 6) begin
        m0_req_i = 0; m1_req_i = 0;
      end
      @(negedge clk);
      if (i < 6) begin
        checks++;
        if ({m0_gnt_o, m1_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_grant[%0d] got g0g1=%b want %b", i, {m0_gnt_o, m1_gnt_o},
                   (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (i > 0) begin
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_rsp[%0d] got rv=%b want %b", i, {m0_rvalid_o, m1_rvalid_o},
                   ((i - 1) % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      next_cycle();
    end
    s_rvalid_i = 0;
  endtask

  task automatic test_hold();
    do_reset();
    m1_req_i = 1; m1_addr_i = 32'h200;
    m0_addr_i = 32'h300;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) m0_req_i = 1;
      s_gnt_i = (i >= 3);
      if (i == 4) m1_req_i = 0;
      @(negedge clk);
      if (i < 4) begin
        checks++;
        if (s_addr_o !== 32'h200 || {m0_gnt_o, m1_gnt_o} !== ((i == 3) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL hold[%0d] got addr=%h g0g1=%b want addr=00000200 g0g1=%b",
                   i, s_addr_o, {m0_gnt_o, m1_gnt_o}, (i == 3) ? 2'b01 : 2'b00);
        end
      end else begin
        checks++;
        if (s_addr_o !== 32'h300 || {m0_gnt_o, m1_gnt_o} !== 2'b10) begin
          errors++;
          $display("FAIL hold_m0 got addr=%h g0g1=%b want 00000300 10",
                   s_addr_o, {m0_gnt_o, m1_gnt_o});
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h40; s_gnt_i = 1;
    for (int i = 0; i < 7; i++) begin
      s_rvalid_i = (i == 5);
      s_rdata_i  = 32'h1234_5678;
      @(negedge clk);
      if (i < 2 || i == 5) begin
        checks++;
        if ({s_req_o, m0_gnt_o} !== 2'b11 || m0_rvalid_o !== (i == 5)) begin
          errors++;
          $display("FAIL full_issue[%0d] got req/g0=%b rv0=%b want 11 rv0=%b",
                   i, {s_req_o, m0_gnt_o}, m0_rvalid_o, i == 5);
        end
      end else begin
        checks++;
        if ({s_req_o, m0_gnt_o, busy_o} !== 3'b001) begin
          errors++;
          $display("FAIL full_stall[%0d] got req/g0/busy=%b want 001", i, {s_req_o, m0_gnt_o, busy_o});
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    s_rvalid_i = 1; s_rdata_i = 32'hBAD;
    @(negedge clk);
    checks++;
    if ({m0_rvalid_o, m1_rvalid_o, spurious_rsp_o} !== 3'b000) begin
      errors++;
      $display("FAIL spur_first got rv0/rv1/spur=%b want 000", {m0_rvalid_o, m1_rvalid_o, spurious_rsp_o});
    end
    next_cycle();
    s_rvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (spurious_rsp_o !== 1'b1) begin
        errors++;
        $display("FAIL spur_sticky[%0d] got %b want 1", i, spurious_rsp_o);
      end
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (spurious_rsp_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear got %b want 0", spurious_rsp_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h80; s_gnt_i = 1;
    next_cycle();
    next_cycle();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({busy_o, s_req_o} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_idle got busy/req=%b want 00", {busy_o, s_req_o});
    end
    next_cycle();
    s_rvalid_i = 1;
    @(negedge clk);
    checks++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_rsp got rv=%b want 00", {m0_rvalid_o, m1_rvalid_o});
    end
    next_cycle();
    s_rvalid_i = 0;
    m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1;
    @(negedge clk);
    checks++;
    if ({spurious_rsp_o, m0_gnt_o, m1_gnt_o} !== 3'b110) begin
      errors++;
      $display("FAIL rstmid_after got spur/g0/g1=%b want 110", {spurious_rsp_o, m0_gnt_o, m1_gnt_o});
    end
    next_cycle();
    idle_inputs();
  endtask

  // Randomized traffic against a transaction-level model of the port.
  task automatic test_random();
    int q[$];          // IDs of accepted, unanswered requests, oldest first
    int pend;          // master whose request is stalled by the memory, -1 if none
    int last;          // winner of the previous handshake
    bit spur;
    int s;
    bit r0, r1, rq, ereq, hs, erv0, erv1, ebusy;
    bit [31:0] a0, a1, d0, d1, eaddr, edata;
    do_reset();
    pend = -1; last = 1; spur = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) == 0);
      a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
      m0_req_i = r0; m0_addr_i = a0; m0_wdata_i = d0; m0_we_i = a0[0]; m0_be_i = a0[7:4];
      m1_req_i = r1; m1_addr_i = a1; m1_wdata_i = d1; m1_we_i = a1[0]; m1_be_i = a1[7:4];
      s_gnt_i    = ($urandom_range(0, 1) == 1);
      s_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
      s_rdata_i  = $urandom;

      if (pend >= 0) s = pend;
      else if (r0 && r1) s = (last == 0) ? 1 : 0;
      else if (r0) s = 0;
      else if (r1) s = 1;
      else s = -1;
      rq    = (s == 0) ? r0 : ((s == 1) ? r1 : 1'b0);
      ereq  = rq && ((q.size() < MAX_OUT) || s_rvalid_i);
      hs    = ereq && s_gnt_i;
      erv0  = s_rvalid_i && (q.size() > 0) && (q[0] == 0);
      erv1  = s_rvalid_i && (q.size() > 0) && (q[0] == 1);
      ebusy = (q.size() > 0) || ereq;
      eaddr = (s == 1) ? a1 : a0;
      edata = (s == 1) ? d1 : d0;

      @(negedge clk);
      checks++;
      if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, spurious_rsp_o} !==
          {ereq, hs && s == 0, hs && s == 1, erv0, erv1, ebusy, spur}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got req/g0/g1/rv0/rv1/busy/spur=%b want %b", cyc,
                 {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, spurious_rsp_o},
                 {ereq, hs && s == 0, hs && s == 1, erv0, erv1, ebusy, spur});
      end
      if (ereq) begin
        checks++;
        if (s_addr_o !== eaddr || s_wdata_o !== edata || s_we_o !== eaddr[0] || s_be_o !== eaddr[7:4]) begin
          errors++;
          $display("FAIL rand_payload[%0d] got addr=%h wdata=%h want addr=%h wdata=%h",
                   cyc, s_addr_o, s_wdata_o, eaddr, edata);
        end
      end

      if (s_rvalid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else spur = 1;
      end
      if (hs) begin
        q.push_back(s);
        last = s;
        pend = -1;
      end else if (pend >= 0 && !rq) begin
        pend = -1;
      end else if (pend < 0 && ereq && !s_gnt_i) begin
        pend = s;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_full();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
